// File: rtl/sobel_sdram_writer.sv
// sobel_sdram_writer: packs pairs of Sobel FIFO bytes (raw or binarised) into 16-bit
// SDRAM word writes, one frame of H_ACTIVE*V_ACTIVE/2 words per frame_start.
module sobel_sdram_writer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_rdempty,
    input  logic [7:0]        fifo_dout,
    output logic              rd_fifo,
    input  logic              frame_start,
    input  logic              thresh_en,
    input  logic [7:0]        threshold,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              frame_done,
    output logic [7:0]        drop_count
);
    typedef enum logic [2:0] {IDLE, FETCH_LO, CAP_LO, FETCH_HI, CAP_HI, WRITE} state_t;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE / 2 - 1);

    state_t            state_q;
    logic              wr_valid_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [15:0]       wr_data_q;
    logic              frame_done_q;
    logic [7:0]        drop_count_q;
    logic [7:0]        pix_d;
    logic              abort_d;
    logic              busy_d;

    assign pix_d   = thresh_en ? ((fifo_dout >= threshold) ? 8'hFF : 8'h00) : fifo_dout;
    assign abort_d = frame_start && state_q != IDLE;
    assign busy_d  = state_q != FETCH_LO || wr_addr_q != '0;
    // no read while resetting or aborting, so a byte is never popped only to be thrown away
    assign rd_fifo = !rst && !frame_start && !fifo_rdempty
                     && (state_q == FETCH_LO || state_q == FETCH_HI);

    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign drop_count = drop_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            frame_done_q <= 1'b0;
            if (abort_d) begin
                state_q    <= FETCH_LO;
                wr_valid_q <= 1'b0;
                wr_addr_q  <= '0;
                wr_data_q  <= '0;
                if (busy_d && drop_count_q != 8'hFF)
                    drop_count_q <= drop_count_q + 8'd1;
            end else begin
                case (state_q)
                    IDLE:     if (frame_start) state_q <= FETCH_LO;
                    FETCH_LO: if (!fifo_rdempty) state_q <= CAP_LO;
                    CAP_LO: begin
                        wr_data_q[7:0] <= pix_d;
                        state_q        <= FETCH_HI;
                    end
                    FETCH_HI: if (!fifo_rdempty) state_q <= CAP_HI;
                    CAP_HI: begin
                        wr_data_q[15:8] <= pix_d;
                        wr_valid_q      <= 1'b1;
                        state_q         <= WRITE;
                    end
                    WRITE: if (wr_ready) begin
                        wr_valid_q   <= 1'b0;
                        frame_done_q <= wr_addr_q == LAST_ADDR;
                        wr_addr_q    <= (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + ADDR_W'(1);
                        state_q      <= (wr_addr_q == LAST_ADDR) ? IDLE : FETCH_LO;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sobel_sdram_writer.sv
// tb_sobel_sdram_writer: byte-queue FIFO model plus word scoreboard for sobel_sdram_writer,
// with directed scenarios and a randomised full frame on a small 16x8 image.
module tb_sobel_sdram_writer;
    localparam int H = 16, V = 8, AW = 10, NW = H * V / 2;
    localparam logic [AW-1:0] LAST = AW'(NW - 1);

    logic          clk = 0, rst = 1, fifo_rdempty = 1, frame_start = 0, thresh_en = 0, wr_ready = 0;
    logic [7:0]    fifo_dout = 0, threshold = 0;
    logic          rd_fifo, wr_valid, frame_done;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic [7:0]    drop_count;

    sobel_sdram_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .fifo_rdempty(fifo_rdempty), .fifo_dout(fifo_dout), .rd_fifo(rd_fifo),
        .frame_start(frame_start), .thresh_en(thresh_en), .threshold(threshold), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    logic [7:0]    fq[$];
    logic [AW-1:0] ea[$];
    logic [15:0]   ed[$];
    int            n_chk = 0, n_fail = 0, rd_cnt = 0, acc_cnt = 0, fd_cnt = 0, word_idx = 0;
    bit            stall_en = 0, rnd_ready = 0, have_lo = 0;
    logic [7:0]    lo_b;
    logic [AW-1:0] acc_addr;
    logic [15:0]   acc_data;

    function automatic logic [7:0] proc(input logic [7:0] b);
        return thresh_en ? ((b >= threshold) ? 8'hFF : 8'h00) : b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        fq.push_back(b);
        if (have_lo) begin
            ed.push_back({proc(b), lo_b});
            ea.push_back(AW'(word_idx));
            word_idx = (word_idx + 1) % NW;
            have_lo  = 0;
        end else begin
            lo_b    = proc(b);
            have_lo = 1;
        end
    endtask

    task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
        push_byte(a);
        push_byte(b);
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) push_pair(8'($urandom), 8'($urandom));
    endtask

    task automatic model_clear();
        ea.delete();
        ed.delete();
        have_lo  = 0;
        word_idx = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) wr_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_acc(input int target);
        int n = 0;
        while (acc_cnt < target && n < 2000) begin tick(); n++; end
        chk("acc_timeout", acc_cnt >= target, 1);
    endtask

    task automatic wait_rd(input int target);
        int n = 0;
        while (rd_cnt < target && n < 2000) begin tick(); n++; end
        chk("rd_timeout", rd_cnt >= target, 1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!wr_valid && n < 2000) begin tick(); n++; end
        chk("valid_timeout", wr_valid, 1);
    endtask

    // FIFO model: pops on rd_fifo, data appears the following cycle
    initial forever begin
        @(posedge clk);
        if (rd_fifo) begin
            fifo_dout <= fq.pop_front();
            rd_cnt    <= rd_cnt + 1;
        end
        fifo_rdempty <= (fq.size() == 0) || (stall_en && $urandom_range(0, 2) == 0);
    end

    // per-cycle compare against the scoreboard and protocol rules
    initial begin
        bit            done_exp = 0, hold = 0, pv = 0, acc;
        logic [AW-1:0] ha;
        logic [15:0]   hd;
        int            cyc = 0, last_rise = -100;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                done_exp = 0; hold = 0; pv = 0;
            end else begin
                if (rd_fifo && fifo_rdempty) chk("rd_while_empty", 1, 0);
                chk("frame_done", frame_done, done_exp);
                if (frame_done) fd_cnt++;
                if (hold) begin
                    chk("hold_valid", wr_valid, 1);
                    chk("hold_addr", wr_addr, ha);
                    chk("hold_data", wr_data, hd);
                end
                if (wr_valid && !pv) begin
                    chk("throughput", cyc - last_rise >= 5, 1);
                    last_rise = cyc;
                end
                pv       = wr_valid;
                acc      = wr_valid && wr_ready && !frame_start;
                done_exp = acc && wr_addr == LAST;
                if (acc) begin
                    acc_cnt++;
                    acc_addr = wr_addr;
                    acc_data = wr_data;
                    if (ea.size() == 0) chk("unexpected_write", 1, 0);
                    else begin
                        chk("wr_addr", wr_addr, ea.pop_front());
                        chk("wr_data", wr_data, ed.pop_front());
                    end
                end
                hold = wr_valid && !acc && !frame_start;
                ha   = wr_addr;
                hd   = wr_data;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int            base, n;
        logic [AW-1:0] a;
        logic [15:0]   d;
        logic [7:0]    exp_lo, b1;
        bit            any_v;
        repeat (3) tick();
        chk("rst_valid", wr_valid, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_data", wr_data, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_rd", rd_fifo, 0);
        rst = 0;
        tick();
        // raw mode, first word
        wr_ready = 1;
        frame_start = 1; tick(); frame_start = 0;
        push_pair(8'h12, 8'h34);
        wait_acc(1);
        chk("raw_rd_count", rd_cnt, 2);
        chk("raw_addr", acc_addr, 0);
        chk("raw_data", acc_data, 16'h3412);
        // threshold mode
        thresh_en = 1; threshold = 8'h80;
        push_pair(8'h80, 8'h7F);
        wait_acc(2);
        chk("thr_addr", acc_addr, 1);
        chk("thr_data", acc_data, 16'h00FF);
        // backpressure
        wr_ready = 0;
        push_rand(1);
        wait_valid();
        a = wr_addr; d = wr_data;
        push_rand(1);
        base = rd_cnt;
        repeat (10) begin
            tick();
            chk("bp_valid", wr_valid, 1);
            chk("bp_addr", wr_addr, a);
            chk("bp_data", wr_data, d);
        end
        chk("bp_no_read", rd_cnt, base);
        wr_ready = 1;
        wait_acc(3);
        chk("bp_addr_inc", wr_addr, a + AW'(1));
        wait_acc(4);
        // empty stall in FETCH_HI
        b1 = 8'($urandom); exp_lo = proc(b1);
        base = rd_cnt;
        push_byte(b1);
        wait_rd(base + 1);
        tick();
        repeat (7) begin
            chk("stall_rd", rd_fifo, 0);
            tick();
        end
        chk("stall_lo", wr_data[7:0], exp_lo);
        push_byte(8'($urandom));
        wait_acc(5);
        // randomised remainder of the frame
        thresh_en = 1'($urandom_range(0, 1)); threshold = 8'($urandom);
        stall_en = 1; rnd_ready = 1;
        push_rand(NW - 5);
        n = 0;
        while (fd_cnt < 1 && n < 20000) begin tick(); n++; end
        rnd_ready = 0; wr_ready = 1; stall_en = 0;
        tick();
        chk("frame_done_count", fd_cnt, 1);
        chk("frame_acc_count", acc_cnt, NW);
        chk("frame_addr_wrap", wr_addr, 0);
        chk("frame_queue_empty", ea.size(), 0);
        // idle ignores a non-empty FIFO
        push_rand(1);
        base = rd_cnt;
        repeat (20) tick();
        chk("idle_no_read", rd_cnt, base);
        frame_start = 1; tick(); frame_start = 0;
        chk("idle_start_no_drop", drop_count, 0);
        wait_acc(NW + 1);
        push_rand(36);
        wait_acc(NW + 37);
        chk("addr_37", wr_addr, 37);
        // abort in CAP_HI
        push_rand(1);
        base = rd_cnt;
        wait_rd(base + 2);
        frame_start = 1; tick(); frame_start = 0;
        model_clear();
        chk("abort_drop", drop_count, 1);
        chk("abort_addr", wr_addr, 0);
        chk("abort_valid", wr_valid, 0);
        any_v = 0;
        repeat (10) begin tick(); any_v |= wr_valid; end
        chk("abort_no_write", any_v, 0);
        // frame_start beats wr_ready in WRITE
        wr_ready = 0;
        push_rand(1);
        wait_valid();
        tick(); tick();
        base = acc_cnt;
        wr_ready = 1; frame_start = 1; tick(); frame_start = 0; wr_ready = 0;
        model_clear();
        chk("prio_valid", wr_valid, 0);
        chk("prio_addr", wr_addr, 0);
        chk("prio_drop", drop_count, 2);
        chk("prio_done", frame_done, 0);
        chk("prio_no_acc", acc_cnt, base);
        // reset mid-frame
        push_rand(1);
        wait_valid();
        rst = 1; tick();
        chk("mid_rst_valid", wr_valid, 0);
        chk("mid_rst_addr", wr_addr, 0);
        chk("mid_rst_data", wr_data, 0);
        chk("mid_rst_done", frame_done, 0);
        chk("mid_rst_drop", drop_count, 0);
        chk("mid_rst_rd", rd_fifo, 0);
        rst = 0;
        model_clear();
        tick();
        // fresh frame after reset starts at address 0
        wr_ready = 1;
        frame_start = 1; tick(); frame_start = 0;
        base = acc_cnt;
        push_rand(1);
        wait_acc(base + 1);
        chk("restart_addr", acc_addr, 0);
        repeat (3) tick();
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
